// File: rtl/hidden_cpu_pkg.sv
// Shared definitions for the HiddenCPU instruction sequencer.
//   - fetch FSM state type
//   - instruction word field positions
//   - bit positions on the synthesised CPU input bus
package hidden_cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRST_A = 3'd1,
    ST_CRST_B = 3'd2,
    ST_SETUP  = 3'd3,
    ST_PULSE  = 3'd4,
    ST_SAMPLE = 3'd5
  } fetch_state_e;

  // Instruction word: [1:0] opcode, [3:2] reg0 addr, [5:4] reg1 addr
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned R0_LSB  = 2;
  localparam int unsigned R1_LSB  = 4;
  localparam int unsigned INSTR_W = 6;

  // CPU input bus layout
  localparam int unsigned CPU_CLK_BIT   = 0;
  localparam int unsigned CPU_RST_BIT   = 1;
  localparam int unsigned CPU_INSTR_LSB = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hidden_cpu_prog_buf.sv
// Program buffer: DEPTH x INSTR_W flop array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
//   clk_i    system clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
module hidden_cpu_prog_buf
  import hidden_cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hidden_cpu_fetch.sv
// Instruction sequencer for HiddenRoom_HiddenCPU. Holds a program loaded over
// a valid/ready port and synthesises the CPU input bus (clk, rst, instr),
// reading the CPU output bus back as the program counter.
//   clk, rst          system clock, async active-low reset
//   load_valid/data   program word offer; load_ready accepts (IDLE, not full)
//   load_clear        empty the buffer (IDLE only)
//   run, step         free-run level / single-step pulse
//   pc_in             CPU output bus, read as PC
//   cpu_in            CPU input bus: [0] clk, [1] rst, [7:2] instruction
//   busy, halted      FSM not idle / PC left the loaded program (sticky)
//   fill_count        words loaded
//   step_count        instructions executed, saturating at 255
module hidden_cpu_fetch
  import hidden_cpu_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [5:0]        load_data,
  output logic              load_ready,
  input  logic              load_clear,
  input  logic              run,
  input  logic              step,
  input  logic [7:0]        pc_in,
  output logic [7:0]        cpu_in,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W:0]   fill_count,
  output logic [7:0]        step_count
);

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      HOLD_INIT = 4'(HOLD_CYCLES - 1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W:0]    fill_q, fill_d;
  logic [7:0]         step_q, step_d;
  logic [7:0]         pc_q, pc_d;
  logic               halted_q, halted_d;
  logic               need_rst_q, need_rst_d;
  logic [3:0]         hold_q, hold_d;

  logic               in_idle;
  logic               buf_we;
  logic               start;
  logic               pc_oob;
  logic [INSTR_W-1:0] rd_instr;
  logic [INSTR_W-1:0] instr_vis;

  assign in_idle    = (state_q == ST_IDLE);
  assign load_ready = in_idle && (fill_q < DEPTH_C);
  assign buf_we     = load_ready && load_valid && !load_clear;
  assign start      = (run || step) && (fill_q != '0) && !halted_q && !load_clear;
  assign pc_oob     = (pc_q >= 8'(fill_q));

  hidden_cpu_prog_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (fill_q[ADDR_W-1:0]),
    .wdata_i (load_data),
    .raddr_i (pc_q[ADDR_W-1:0]),
    .rdata_o (rd_instr)
  );

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    step_d     = step_q;
    pc_d       = pc_q;
    halted_d   = halted_q;
    need_rst_d = need_rst_q;
    hold_d     = HOLD_INIT;

    unique case (state_q)
      ST_IDLE: begin
        if (load_clear) begin
          fill_d     = '0;
          step_d     = '0;
          halted_d   = 1'b0;
          need_rst_d = 1'b1;
        end else if (buf_we) begin
          fill_d     = fill_q + 1'b1;
          need_rst_d = 1'b1;
        end
        // A word written in the start cycle changes the program, so it also
        // forces the CPU reset sequence.
        if (start) begin
          state_d = (need_rst_q || buf_we) ? ST_CRST_A : ST_SETUP;
        end
      end
      ST_CRST_A: state_d = ST_CRST_B;
      ST_CRST_B: begin
        pc_d       = '0;
        need_rst_d = 1'b0;
        state_d    = ST_SETUP;
      end
      ST_SETUP: begin
        if (pc_oob) begin
          halted_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (hold_q == '0) begin
          state_d = ST_PULSE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_PULSE: state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        pc_d    = pc_in;
        step_d  = sat_inc8(step_q);
        state_d = run ? ST_SETUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fill_q     <= '0;
      step_q     <= '0;
      pc_q       <= '0;
      halted_q   <= 1'b0;
      need_rst_q <= 1'b1;
      hold_q     <= HOLD_INIT;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      step_q     <= step_d;
      pc_q       <= pc_d;
      halted_q   <= halted_d;
      need_rst_q <= need_rst_d;
      hold_q     <= hold_d;
    end
  end

  // cpu_in is decoded from registered state only, so it drops with the async
  // reset and the instruction bits stay constant from SETUP through SAMPLE.
  // An out-of-range PC never reaches the bus: it shows zero while halting.
  assign instr_vis = pc_oob ? '0 : rd_instr;

  always_comb begin
    cpu_in = '0;
    unique case (state_q)
      ST_CRST_A: cpu_in[CPU_RST_BIT] = 1'b1;
      ST_CRST_B: begin
        cpu_in[CPU_RST_BIT] = 1'b1;
        cpu_in[CPU_CLK_BIT] = 1'b1;
      end
      ST_SETUP, ST_SAMPLE: cpu_in[CPU_INSTR_LSB +: INSTR_W] = instr_vis;
      ST_PULSE: begin
        cpu_in[CPU_INSTR_LSB +: INSTR_W] = instr_vis;
        cpu_in[CPU_CLK_BIT]              = 1'b1;
      end
      default: cpu_in = '0;
    endcase
  end

  assign busy       = !in_idle;
  assign halted     = halted_q;
  assign fill_count = fill_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_hidden_cpu_fetch.sv
module tb_hidden_cpu_fetch;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned H      = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            load_valid = 1'b0;
  logic [5:0]      load_data = '0;
  logic            load_ready;
  logic            load_clear = 1'b0;
  logic            run = 1'b0;
  logic            step = 1'b0;
  logic [7:0]      pc_in = '0;
  logic [7:0]      cpu_in;
  logic            busy;
  logic            halted;
  logic [ADDR_W:0] fill_count;
  logic [7:0]      step_count;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q [$];
  logic [5:0] prog [DEPTH];
  logic [7:0] model_pc = '0;
  logic       pulse_seen = 1'b0;
  logic [5:0] last_instr = '0;

  hidden_cpu_fetch #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .HOLD_CYCLES (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_clear (load_clear),
    .run        (run),
    .step       (step),
    .pc_in      (pc_in),
    .cpu_in     (cpu_in),
    .busy       (busy),
    .halted     (halted),
    .fill_count (fill_count),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  // CPU model: PC advances by one per CPU clock, cleared by a clock with rst high
  initial forever begin
    @(posedge cpu_in[0]);
    if (cpu_in[1]) model_pc = '0;
    else           model_pc = model_pc + 8'd1;
    pc_in = model_pc;
  end

  // Scoreboard: each instruction pulse pops the expected instruction
  initial forever begin
    @(negedge clk);
    if (pulse_seen) begin
      checks++;
      if (cpu_in[7:2] !== last_instr) begin
        failures++;
        $display("FAIL instr_hold_after_pulse got=%0h exp=%0h", cpu_in[7:2], last_instr);
      end
      pulse_seen = 1'b0;
    end
    if (cpu_in[0] === 1'b1 && cpu_in[1] === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL extra_pulse got=%0h exp=none", cpu_in);
      end else begin
        last_instr = exp_q.pop_front();
        if (cpu_in[7:2] !== last_instr) begin
          failures++;
          $display("FAIL pulse_instr got=%0h exp=%0h", cpu_in[7:2], last_instr);
        end
        pulse_seen = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    load_clear = 1'b1;
    tick();
    load_clear = 1'b0;
  endtask

  task automatic load_word(input logic [5:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (cpu_in !== 8'h00)    begin failures++; $display("FAIL rst_cpu_in got=%0h exp=0", cpu_in); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (fill_count !== '0)   begin failures++; $display("FAIL rst_fill got=%0d exp=0", fill_count); end
    checks++; if (step_count !== '0)   begin failures++; $display("FAIL rst_steps got=%0d exp=0", step_count); end
    checks++; if (halted !== 1'b0)     begin failures++; $display("FAIL rst_halted got=%0b exp=0", halted); end
    rst = 1'b1;
    tick();
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", load_ready); end
  endtask

  task automatic test_load_full();
    logic [5:0] v;
    int exp_fill;
    for (int i = 0; i < 17; i++) begin
      v = 6'($urandom);
      if (i < 16) prog[i] = v;
      load_valid = 1'b1;
      load_data  = v;
      tick();
      exp_fill = (i + 1 > 16) ? 16 : i + 1;
      checks++;
      if (fill_count !== (ADDR_W+1)'(exp_fill)) begin
        failures++; $display("FAIL full_fill[%0d] got=%0d exp=%0d", i, fill_count, exp_fill);
      end
      if (i >= 15) begin
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL full_ready[%0d] got=%0b exp=0", i, load_ready); end
      end
    end
    load_valid = 1'b0;
    // Run the whole buffer: PC 16 equals fill_count and must halt
    for (int i = 0; i < 16; i++) exp_q.push_back(prog[i]);
    run = 1'b1;
    for (int c = 0; c < 300 && halted !== 1'b1; c++) tick();
    run = 1'b0;
    checks++; if (halted !== 1'b1)       begin failures++; $display("FAIL full_halted got=%0b exp=1", halted); end
    checks++; if (step_count !== 8'd16)  begin failures++; $display("FAIL full_steps got=%0d exp=16", step_count); end
    repeat (4) tick();
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL full_busy got=%0b exp=0", busy); end
    checks++; if (exp_q.size() != 0)     begin failures++; $display("FAIL full_pending got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_clear_collision();
    load_clear = 1'b1; load_valid = 1'b1; load_data = 6'h2A;
    tick();
    load_clear = 1'b0; load_valid = 1'b0;
    checks++; if (fill_count !== '0)   begin failures++; $display("FAIL clr_fill got=%0d exp=0", fill_count); end
    checks++; if (halted !== 1'b0)     begin failures++; $display("FAIL clr_halted got=%0b exp=0", halted); end
    checks++; if (step_count !== '0)   begin failures++; $display("FAIL clr_steps got=%0d exp=0", step_count); end
    load_word(6'h11);
    load_word(6'h22);
    load_clear = 1'b1; load_valid = 1'b1; load_data = 6'h33;
    tick();
    load_clear = 1'b0; load_valid = 1'b0;
    checks++; if (fill_count !== '0)   begin failures++; $display("FAIL clr2_fill got=%0d exp=0", fill_count); end
  endtask

  task automatic test_first_step();
    logic [7:0] e;
    int n;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      prog[i] = 6'($urandom);
      load_word(prog[i]);
    end
    exp_q.push_back(prog[0]);
    pulse_step();
    n = 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      if (k == 0)           e = 8'h02;
      else if (k == 1)      e = 8'h03;
      else if (k <= H + 1)  e = {prog[0], 2'b00};
      else if (k == H + 2)  e = {prog[0], 2'b01};
      else                  e = {prog[0], 2'b00};
      checks++;
      if (cpu_in !== e) begin failures++; $display("FAIL step1_seq[%0d] got=%0h exp=%0h", k, cpu_in, e); end
      n++;
      tick();
    end
    checks++; if (n != H + 4)          begin failures++; $display("FAIL step1_busy got=%0d exp=%0d", n, H + 4); end
    checks++; if (step_count !== 8'd1) begin failures++; $display("FAIL step1_count got=%0d exp=1", step_count); end
    // Second step: CPU already reset, straight to SETUP with the next word
    exp_q.push_back(prog[1]);
    pulse_step();
    checks++;
    if (cpu_in !== {prog[1], 2'b00}) begin failures++; $display("FAIL step2_first got=%0h exp=%0h", cpu_in, {prog[1], 2'b00}); end
    n = 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin n++; tick(); end
    checks++; if (n != H + 2)          begin failures++; $display("FAIL step2_busy got=%0d exp=%0d", n, H + 2); end
    checks++; if (step_count !== 8'd2) begin failures++; $display("FAIL step2_count got=%0d exp=2", step_count); end
    checks++; if (exp_q.size() != 0)   begin failures++; $display("FAIL step_pending got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back_run_step();
    do_clear();
    for (int i = 0; i < 4; i++) begin
      prog[i] = 6'($urandom);
      load_word(prog[i]);
      exp_q.push_back(prog[i]);
    end
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    for (int c = 0; c < 12 && !(busy === 1'b1 && cpu_in[1:0] === 2'b00); c++) tick();
    pulse_step();
    for (int c = 0; c < 100 && halted !== 1'b1; c++) tick();
    run = 1'b0;
    checks++; if (halted !== 1'b1)       begin failures++; $display("FAIL run_halted got=%0b exp=1", halted); end
    checks++; if (step_count !== 8'd4)   begin failures++; $display("FAIL run_steps got=%0d exp=4", step_count); end
    repeat (4) tick();
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL run_busy got=%0b exp=0", busy); end
    checks++; if (exp_q.size() != 0)     begin failures++; $display("FAIL run_pending got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_step_while_busy();
    int n;
    do_clear();
    prog[0] = 6'($urandom);
    prog[1] = 6'($urandom);
    load_word(prog[0]);
    load_word(prog[1]);
    exp_q.push_back(prog[0]);
    pulse_step();
    tick();
    tick();
    checks++;
    if (cpu_in !== {prog[0], 2'b00}) begin failures++; $display("FAIL sbusy_setup got=%0h exp=%0h", cpu_in, {prog[0], 2'b00}); end
    pulse_step();
    n = 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin n++; tick(); end
    repeat (3) tick();
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL sbusy_idle got=%0b exp=0", busy); end
    checks++; if (step_count !== 8'd1)   begin failures++; $display("FAIL sbusy_count got=%0d exp=1", step_count); end
    checks++; if (exp_q.size() != 0)     begin failures++; $display("FAIL sbusy_pending got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    int found;
    do_clear();
    load_word(6'h15);
    load_word(6'h2B);
    pulse_step();
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (cpu_in[0] === 1'b1 && cpu_in[1] === 1'b0) found = 1;
      else tick();
    end
    checks++; if (found != 1) begin failures++; $display("FAIL arst_pulse got=%0d exp=1", found); end
    #2 rst = 1'b0;
    #1;
    checks++; if (cpu_in !== 8'h00)  begin failures++; $display("FAIL arst_cpu_in got=%0h exp=0", cpu_in); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL arst_busy got=%0b exp=0", busy); end
    checks++; if (fill_count !== '0) begin failures++; $display("FAIL arst_fill got=%0d exp=0", fill_count); end
    tick();
    rst = 1'b1;
    tick();
    prog[0] = 6'($urandom);
    load_word(prog[0]);
    exp_q.push_back(prog[0]);
    pulse_step();
    checks++; if (cpu_in !== 8'h02)  begin failures++; $display("FAIL arst_crst got=%0h exp=02", cpu_in); end
    for (int k = 0; k < 40 && busy === 1'b1; k++) tick();
    checks++; if (step_count !== 8'd1) begin failures++; $display("FAIL arst_count got=%0d exp=1", step_count); end
    checks++; if (exp_q.size() != 0)   begin failures++; $display("FAIL arst_pending got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_clear_collision();
    test_first_step();
    test_back_to_back_run_step();
    test_step_while_busy();
    test_async_reset();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
